// File: rtl/trace_buffer.sv
// Instruction-trace capture buffer: circular pre-trigger history, post-trigger tail, freeze and pop readout.
// Optional per-entry cycle timestamps (rd_ts) when TRACE_TIMESTAMP_EN is defined.
module trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trig,
    input  logic [CW-1:0]              post_cnt,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_alu,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_inst,
    output logic [XLEN-1:0]            rd_alu,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]                rd_ts,
`endif
    output logic                       wrapped
);
    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 2 * XLEN + 64;
`else
    localparam int EW = 2 * XLEN + 32;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] REM_ONE  = CW'(1);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            wrapped_q, wrapped_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic            rd_valid_q;
    logic [EW-1:0]   rd_data_q;
    logic            wr_en;
    logic            rd_fire;
    logic [AW-1:0]   rd_idx;
    logic [EW-1:0]   wr_data;

    logic [EW-1:0]   mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]     ts_q;

    // The arm cycle is time 0, so the counter reads 1 in the cycle after arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else if (arm) begin
            ts_q <= 32'd1;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign wr_data = {ts_q, in_pc, in_inst, in_alu};
    assign rd_ts   = rd_data_q[EW-1 -: 32];
`else
    assign wr_data = {in_pc, in_inst, in_alu};
`endif

    // Oldest entry sits count entries behind the write pointer (modulo DEPTH).
    assign rd_idx = wr_ptr_q - count_q[AW-1:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        rd_fire     = 1'b0;
        if (arm) begin
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    wr_en = in_valid;
                    if (trig) begin
                        remaining_d = post_cnt;
                        state_d     = (post_cnt == '0) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        wr_en       = 1'b1;
                        remaining_d = remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    rd_fire = rd_req && (count_q != '0);
                end
                default: ;
            endcase
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (count_q == CNT_FULL) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            if (rd_fire) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem[rd_idx];
            end
        end
    end

    assign state    = state_q;
    assign count    = count_q;
    assign wrapped  = wrapped_q;
    assign rd_valid = rd_valid_q;
    assign rd_alu   = rd_data_q[XLEN-1:0];
    assign rd_inst  = rd_data_q[XLEN+31:XLEN];
    assign rd_pc    = rd_data_q[2*XLEN+31:XLEN+32];
endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus random traffic against a queue-based model.
// Timestamp checks are included when TRACE_TIMESTAMP_EN is defined.
module tb_trace_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        arm, trig, in_valid, rd_req;
    logic [7:0]  post_cnt;
    logic [31:0] in_pc, in_inst, in_alu;
    logic        rd_valid, wrapped;
    logic [31:0] rd_pc, rd_inst, rd_alu;
    logic [1:0]  state;
    logic [4:0]  count;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] rd_ts;
`endif

    always #5 clk = ~clk;

    trace_buffer #(.XLEN(32), .DEPTH(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .post_cnt(post_cnt),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_alu(in_alu),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_alu(rd_alu), .state(state), .count(count),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .wrapped(wrapped)
    );

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
    } entry_t;

    // Reference model: the buffer is a queue of at most 16 entries, oldest at the front.
    int     m_state;
    entry_t m_q[$];
    bit     m_wrapped;
    bit     m_rv;
    entry_t m_rd;
    int     m_rem;
    logic [31:0] m_t;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_wrapped = 1'b0;
        m_rv = 1'b0;
        m_rd = '0;
        m_rem = 0;
        m_t = '0;
    endtask

    task automatic model_push(input entry_t e);
        m_q.push_back(e);
        if (m_q.size() > 16) begin
            void'(m_q.pop_front());
            m_wrapped = 1'b1;
        end
    endtask

    task automatic check_all();
        check_value("state", 64'(state), 64'(m_state));
        check_value("count", 64'(count), 64'(m_q.size()));
        check_value("wrapped", 64'(wrapped), 64'(m_wrapped));
        check_value("rd_valid", 64'(rd_valid), 64'(m_rv));
        check_value("rd_pc", 64'(rd_pc), 64'(m_rd.pc));
        check_value("rd_inst", 64'(rd_inst), 64'(m_rd.inst));
        check_value("rd_alu", 64'(rd_alu), 64'(m_rd.alu));
`ifdef TRACE_TIMESTAMP_EN
        check_value("rd_ts", 64'(rd_ts), 64'(m_rd.ts));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, clock the DUT, then compare.
    task automatic drive(input bit a, input bit t, input int pc_n, input bit v,
                         input logic [31:0] pc, input bit rr);
        entry_t e;
        arm = a; trig = t; post_cnt = 8'(pc_n); in_valid = v; in_pc = pc;
        in_inst = $urandom; in_alu = $urandom; rd_req = rr;
        e.pc = in_pc; e.inst = in_inst; e.alu = in_alu;
`ifdef TRACE_TIMESTAMP_EN
        e.ts = m_t;
`endif
        m_rv = 1'b0;
        if (a) begin
            m_state = 1;
            m_q.delete();
            m_wrapped = 1'b0;
        end else begin
            case (m_state)
                1: begin
                    if (v) model_push(e);
                    if (t) begin
                        m_rem = pc_n;
                        m_state = (pc_n == 0) ? 3 : 2;
                    end
                end
                2: if (v) begin
                    model_push(e);
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
                3: if (rr && m_q.size() > 0) begin
                    m_rd = m_q.pop_front();
                    m_rv = 1'b1;
                end
                default: ;
            endcase
        end
        m_t = a ? 32'd1 : m_t + 32'd1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp_pc);
        drive(0, 0, 0, 0, 32'd0, 1);
        check_value(tag, 64'(rd_pc), 64'(exp_pc));
        $display("[TB] pop pc=%0h rd_valid=%0d count=%0d", rd_pc, rd_valid, count);
    endtask

    initial begin
        rst = 1'b1; arm = 0; trig = 0; post_cnt = 0; in_valid = 0;
        in_pc = 0; in_inst = 0; in_alu = 0; rd_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores traffic.
        drive(0, 1, 3, 1, 32'h100, 1);
        drive(0, 0, 0, 1, 32'h104, 1);

        // Reset mid-CAPTURE after 5 writes, checked before the next clock edge.
        drive(1, 0, 0, 0, 32'd0, 0);
        drive(0, 1, 10, 1, 32'h0, 0);
        for (int i = 1; i < 5; i++) drive(0, 0, 0, 1, 32'(i * 4), 0);
        check_value("pre_rst_state", 64'(state), 64'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_value("async_rst_state", 64'(state), 64'd0);
        check_value("async_rst_count", 64'(count), 64'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Pre-trigger history plus three post-trigger samples.
        drive(1, 0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 32'(i * 4), 0);
        drive(0, 1, 3, 1, 32'd20, 0);
        for (int i = 6; i < 9; i++) drive(0, 0, 0, 1, 32'(i * 4), 0);
        check_value("s2_state", 64'(state), 64'd3);
        check_value("s2_count", 64'(count), 64'd9);
        check_value("s2_wrapped", 64'(wrapped), 64'd0);
        for (int i = 0; i < 9; i++) pop_expect("s2_pop_pc", 32'(i * 4));
        check_value("s2_empty_count", 64'(count), 64'd0);
        drive(0, 0, 0, 0, 32'd0, 1);
        check_value("s2_empty_rd_valid", 64'(rd_valid), 64'd0);

        // Overflow with immediate freeze (post_cnt = 0).
        drive(1, 0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 32'(i * 4), 0);
        drive(0, 1, 0, 1, 32'd80, 0);
        check_value("s3_state", 64'(state), 64'd3);
        check_value("s3_count", 64'(count), 64'd16);
        check_value("s3_wrapped", 64'(wrapped), 64'd1);
        pop_expect("s3_first_pc", 32'd20);
        for (int i = 1; i < 15; i++) pop_expect("s3_pop_pc", 32'(20 + i * 4));
        pop_expect("s3_last_pc", 32'd80);

        // Post-trigger gaps do not consume the post-trigger budget.
        drive(1, 0, 0, 0, 32'd0, 0);
        drive(0, 1, 2, 1, 32'd0, 0);
        drive(0, 0, 0, 0, 32'd0, 0);
        drive(0, 0, 0, 1, 32'd4, 0);
        drive(0, 0, 0, 0, 32'd0, 0);
        drive(0, 0, 0, 0, 32'd0, 0);
        check_value("s4_still_capture", 64'(state), 64'd2);
        drive(0, 0, 0, 1, 32'd8, 0);
        check_value("s4_state", 64'(state), 64'd3);
        check_value("s4_count", 64'(count), 64'd3);

        // arm beats in_valid/trig in CAPTURE; rd_req ignored in ARMED.
        drive(1, 0, 0, 0, 32'd0, 0);
        drive(0, 1, 5, 1, 32'd0, 0);
        drive(0, 0, 0, 1, 32'd4, 0);
        drive(1, 1, 0, 1, 32'd8, 0);
        check_value("s5_state", 64'(state), 64'd1);
        check_value("s5_count", 64'(count), 64'd0);
        drive(0, 0, 0, 0, 32'd0, 1);
        check_value("s5_rd_valid", 64'(rd_valid), 64'd0);

`ifdef TRACE_TIMESTAMP_EN
        // Samples 3 and 7 cycles after arm carry those timestamps.
        drive(1, 0, 0, 0, 32'd0, 0);
        for (int k = 1; k <= 7; k++) drive(0, 0, 0, (k == 3 || k == 7), 32'(k), 0);
        drive(0, 1, 0, 0, 32'd0, 0);
        drive(0, 0, 0, 0, 32'd0, 1);
        check_value("ts_first", 64'(rd_ts), 64'd3);
        drive(0, 0, 0, 0, 32'd0, 1);
        check_value("ts_second", 64'(rd_ts), 64'd7);
`endif

        // Random traffic against the model.
        drive(1, 0, 0, 0, 32'd0, 0);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
                  int'($urandom_range(0, 20)), $urandom_range(0, 99) < 60,
                  $urandom, $urandom_range(0, 99) < 50);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
